// File: rtl/writeback_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// writeback_arbiter_pkg
// Shared widths and types for the register-file writeback arbiter.
//   XLEN      : register / result data width
//   REG_AW    : register address width
//   NUM_REGS  : architectural register count (size of the pending bitmap)
//   wrReq_t   : one register-file write request {we, rd, data}
//   regMask() : one-hot register mask with x0 forced to zero
// ----------------------------------------------------------------------------
package writeback_arbiter_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic              we;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wrReq_t;

    // x0 is hardwired, so its bit never takes part in set/clear operations.
    function automatic logic [NUM_REGS-1:0] regMask(input logic [REG_AW-1:0] rd);
        regMask = (NUM_REGS'(1) << rd) & ~NUM_REGS'(1);
    endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// ----------------------------------------------------------------------------
// writeback_arbiter_if
// Bundles every non-clock signal of the writeback arbiter.
//   WB_*            : pipeline writeback request (no back-pressure)
//   MD_*            : multiply/divide result valid/ready handshake
//   ISSUE_MD/RD     : MD issue notification for the pending scoreboard
//   RS1/RS2/RD_Q    : decode-stage hazard queries, HAZARD is the answer
//   WRITE*          : register-file write port
// Modports: master = producers/decoder side, slave = arbiter side.
// ----------------------------------------------------------------------------
interface writeback_arbiter_if;
    import writeback_arbiter_pkg::*;

    logic              WB_VALID;
    logic [REG_AW-1:0] WB_RD;
    logic [XLEN-1:0]   WB_DATA;
    logic              MD_VALID;
    logic              MD_READY;
    logic [REG_AW-1:0] MD_RD;
    logic [XLEN-1:0]   MD_DATA;
    logic              ISSUE_MD;
    logic [REG_AW-1:0] ISSUE_RD;
    logic [REG_AW-1:0] RS1;
    logic [REG_AW-1:0] RS2;
    logic [REG_AW-1:0] RD_Q;
    logic              HAZARD;
    logic              WRITEENABLE;
    logic [REG_AW-1:0] WRITEADDRESS;
    logic [XLEN-1:0]   WRITEDATA;

    modport master (
        output WB_VALID, WB_RD, WB_DATA,
        output MD_VALID, MD_RD, MD_DATA,
        output ISSUE_MD, ISSUE_RD, RS1, RS2, RD_Q,
        input  MD_READY, HAZARD, WRITEENABLE, WRITEADDRESS, WRITEDATA
    );

    modport slave (
        input  WB_VALID, WB_RD, WB_DATA,
        input  MD_VALID, MD_RD, MD_DATA,
        input  ISSUE_MD, ISSUE_RD, RS1, RS2, RD_Q,
        output MD_READY, HAZARD, WRITEENABLE, WRITEADDRESS, WRITEDATA
    );

endinterface

// File: rtl/md_result_fifo.sv
// ----------------------------------------------------------------------------
// md_result_fifo
// Small synchronous FIFO for returning results (MD unit today, load-miss
// return path later). Head entry is visible combinationally while non-empty.
//   CLK, RESET   : clock, synchronous active-high reset (empties the FIFO)
//   push_i       : write pushData_i at the tail (ignored when full)
//   pushData_i   : entry to store
//   pop_i        : drop the head entry (ignored when empty)
//   headData_o   : current head entry
//   full_o       : no free entry
//   empty_o      : no stored entry
// DEPTH must be a power of two so the pointers wrap for free.
// ----------------------------------------------------------------------------
module md_result_fifo
    import writeback_arbiter_pkg::*;
#(
    parameter int WIDTH = $bits(wrReq_t),
    parameter int DEPTH = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             push_i,
    input  logic [WIDTH-1:0] pushData_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] headData_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    typedef logic [PW:0] count_t;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [PW-1:0]    rdPtr_q, rdPtr_d;
    count_t           count_q, count_d;
    logic             doPush, doPop;

    assign full_o     = (count_q == count_t'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign doPush     = push_i && !full_o;
    assign doPop      = pop_i && !empty_o;
    assign headData_o = mem_q[rdPtr_q];

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge CLK) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= pushData_i;
        end
    end

    // Simultaneous push and pop move both pointers but leave the count alone.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + PW'(1);
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + PW'(1);
        end
        if (doPush && !doPop) begin
            count_d = count_q + count_t'(1);
        end else if (doPop && !doPush) begin
            count_d = count_q - count_t'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// ----------------------------------------------------------------------------
// writeback_arbiter
// Shares the single register-file write port between the pipeline writeback
// stage (highest priority, never stalled) and the multiply/divide unit
// (valid/ready, results buffered in md_result_fifo). Keeps a pending bitmap
// of registers awaiting an MD result and reports HAZARD to decode.
//   CLK, RESET : clock, synchronous active-high reset
//   bus        : writeback_arbiter_if slave modport (all other signals)
// Data/address widths come from writeback_arbiter_pkg; FIFO_DEPTH sizes the
// MD result buffer (power of two, at least 2).
// ----------------------------------------------------------------------------
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                CLK,
    input  logic                RESET,
    writeback_arbiter_if.slave  bus
);

    wrReq_t              port_q, port_d;
    logic [NUM_REGS-1:0] pending_q, pending_d;
    wrReq_t              mdIn;
    wrReq_t              head;
    logic                fifoFull, fifoEmpty;
    logic                mdPush, mdPop;

    // The FIFO entry carries its own write enable so an x0 result is still
    // queued and popped but never reaches the register file.
    assign mdIn = '{we: (bus.MD_RD != '0), rd: bus.MD_RD, data: bus.MD_DATA};

    // Ready depends only on the registered count; a full FIFO does not accept
    // even if it is being drained this cycle.
    assign bus.MD_READY = !fifoFull && !RESET;
    assign mdPush       = bus.MD_VALID && bus.MD_READY;
    assign mdPop        = !bus.WB_VALID && !fifoEmpty;

    md_result_fifo #(
        .WIDTH (($bits(wrReq_t))),
        .DEPTH (FIFO_DEPTH)
    ) u_mdFifo (
        .CLK        (CLK),
        .RESET      (RESET),
        .push_i     (mdPush),
        .pushData_i (mdIn),
        .pop_i      (mdPop),
        .headData_o (head),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty)
    );

    // Port selection and scoreboard update. An idle slot keeps the previous
    // address/data and only drops the enable. A set arriving in the same cycle
    // as the clear of the same register wins, since it belongs to a newer
    // MD instruction.
    always_comb begin
        port_d    = port_q;
        port_d.we = 1'b0;
        pending_d = pending_q;
        if (bus.WB_VALID) begin
            port_d = '{we: (bus.WB_RD != '0), rd: bus.WB_RD, data: bus.WB_DATA};
        end else if (!fifoEmpty) begin
            port_d    = head;
            pending_d = pending_d & ~regMask(head.rd);
        end
        if (bus.ISSUE_MD) begin
            pending_d = pending_d | regMask(bus.ISSUE_RD);
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            port_q    <= '0;
            pending_q <= '0;
        end else begin
            port_q    <= port_d;
            pending_q <= pending_d;
        end
    end

    assign bus.WRITEENABLE  = port_q.we;
    assign bus.WRITEADDRESS = port_q.rd;
    assign bus.WRITEDATA    = port_q.data;
    assign bus.HAZARD       = pending_q[bus.RS1] | pending_q[bus.RS2] | pending_q[bus.RD_Q];

    // Decode must stall on HAZARD, so the pipeline never writes a register
    // that still has an MD result in flight.
    noWbOnPending: assert property (@(posedge CLK) disable iff (RESET)
        !(bus.WB_VALID && pending_q[bus.WB_RD]));

endmodule
